sr_flag_controller: RTL and testbench

//  Shares a bank of NUM_FLAGS sr_flip_flop instances between two requesters (A, B).

---
 rtl/sr_flag_controller_pkg.sv | 24 ++
 rtl/sr_flag_controller_chk.sv | 18 +
 rtl/sr_flip_flop.sv | 33 +++
 rtl/sr_flag_controller.sv | 139 +++++++++++++
 tb/tb_sr_flag_controller.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/sr_flag_controller_pkg.sv
// Shared definitions for the SR flag controller.
//  - state_e : controller FSM states (IDLE waits for a command, APPLY drives one pulse)
//  - OP_*    : command operation encoding (set drives S, clear drives R)
//  - REQ_*   : requester identity, used for the round-robin "last winner" register
//  - flag_hit: decode helper, true when a command index selects a given bank bit
package sr_flag_controller_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_APPLY = 1'b1
  } state_e;

  localparam logic OP_CLR = 1'b0;
  localparam logic OP_SET = 1'b1;
  localparam logic REQ_A  = 1'b0;
  localparam logic REQ_B  = 1'b1;

  // An index outside the bank never equals a valid bit position, so
  // out-of-range commands decode to an empty mask (a harmless no-op).
  function automatic logic flag_hit(input int idx, input int bitpos);
    return (idx == bitpos);
  endfunction

endpackage

// File: rtl/sr_flag_controller_chk.sv
// Simulation checker for the SR flag bank drive.
//  clk   : controller clock
//  s_bus : per-flag S drive
//  r_bus : per-flag R drive
// Flags any clock edge on which a bank bit sees S and R together.
module sr_flag_controller_chk #(
  parameter int NUM_FLAGS = 4
) (
  input logic                 clk,
  input logic [NUM_FLAGS-1:0] s_bus,
  input logic [NUM_FLAGS-1:0] r_bus
);

  // Never drive set and reset into the same cell.
  a_no_s_and_r: assert property (@(posedge clk) ((s_bus & r_bus) == {NUM_FLAGS{1'b0}}))
    else $error("sr_flag_controller_chk: S and R asserted together, S=%b R=%b", s_bus, r_bus);

endmodule

// File: rtl/sr_flip_flop.sv
// Clocked SR flip-flop used as one cell of the flag bank.
//  clk : clock, state changes on posedge
//  S   : set request  (Q -> 1)
//  R   : reset request (Q -> 0)
//  Q   : stored value
//  Qn  : complement of Q
// The cell has no reset of its own; the controller resets it by driving R.
// S=R=1 is never produced by the controller; the cell simply holds in that case.
module sr_flip_flop (
  input  logic clk,
  input  logic S,
  input  logic R,
  output logic Q,
  output logic Qn
);

  logic q_q;

  // Storage cell: set, clear or hold on each rising edge.
  always_ff @(posedge clk) begin
    if (S && !R) begin
      q_q <= 1'b1;
    end else if (R && !S) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_q;
    end
  end

  assign Q  = q_q;
  assign Qn = ~q_q;

endmodule

// File: rtl/sr_flag_controller.sv
// Two-requester set/clear controller for a bank of SR flip-flops.
//  clk, rst            : clock and synchronous active-high reset
//  req_a_* / req_b_*   : valid/ready command channels (idx selects flag, op 1=set 0=clear)
//  busy                : high while a pulse is being applied (no command accepted)
//  err_conflict        : both requesters target the same flag with opposite ops (IDLE only)
//  flags / flags_n     : Q / Qn outputs of the bank
// One command is accepted per two cycles: accept in IDLE, pulse in APPLY.
// Ties are broken round-robin; after reset A wins the first tie.
module sr_flag_controller
  import sr_flag_controller_pkg::*;
#(
  parameter int NUM_FLAGS = 4,
  parameter int IDX_W     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_a_valid,
  input  logic [IDX_W-1:0]     req_a_idx,
  input  logic                 req_a_op,
  output logic                 req_a_ready,
  input  logic                 req_b_valid,
  input  logic [IDX_W-1:0]     req_b_idx,
  input  logic                 req_b_op,
  output logic                 req_b_ready,
  output logic                 busy,
  output logic                 err_conflict,
  output logic [NUM_FLAGS-1:0] flags,
  output logic [NUM_FLAGS-1:0] flags_n
);

  state_e               state_q;
  logic                 rr_last_q;
  logic [IDX_W-1:0]     cmd_idx_q;
  logic                 cmd_op_q;
  logic                 grant_a;
  logic                 grant_b;
  logic [NUM_FLAGS-1:0] mask;
  logic [NUM_FLAGS-1:0] s_bus;
  logic [NUM_FLAGS-1:0] r_bus;

  // Arbitration: only in IDLE and out of reset; a tie goes to whoever did not win last.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!rst && (state_q == ST_IDLE)) begin
      if (req_a_valid && req_b_valid) begin
        if (rr_last_q == REQ_B) begin
          grant_a = 1'b1;
        end else begin
          grant_b = 1'b1;
        end
      end else if (req_a_valid) begin
        grant_a = 1'b1;
      end else if (req_b_valid) begin
        grant_b = 1'b1;
      end else begin
        grant_a = 1'b0;
        grant_b = 1'b0;
      end
    end else begin
      grant_a = 1'b0;
      grant_b = 1'b0;
    end
  end

  // Controller FSM: latch the granted command in IDLE, spend one cycle in APPLY.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      rr_last_q <= REQ_B;
      cmd_idx_q <= {IDX_W{1'b0}};
      cmd_op_q  <= OP_CLR;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant_a || grant_b) begin
            state_q   <= ST_APPLY;
            rr_last_q <= grant_b ? REQ_B : REQ_A;
            cmd_idx_q <= grant_b ? req_b_idx : req_a_idx;
            cmd_op_q  <= grant_b ? req_b_op : req_a_op;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_APPLY: state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  // One-hot select of the latched target flag.
  always_comb begin
    mask = {NUM_FLAGS{1'b0}};
    for (int i = 0; i < NUM_FLAGS; i++) begin
      mask[i] = flag_hit(int'(cmd_idx_q), i);
    end
  end

  // S/R drive: reset forces R on every cell (and drops any pending pulse);
  // APPLY drives exactly one of S or R on the selected cell, so S&R is always 0.
  always_comb begin
    s_bus = {NUM_FLAGS{1'b0}};
    r_bus = {NUM_FLAGS{1'b0}};
    if (rst) begin
      r_bus = {NUM_FLAGS{1'b1}};
    end else if (state_q == ST_APPLY) begin
      s_bus = (cmd_op_q == OP_SET) ? mask : {NUM_FLAGS{1'b0}};
      r_bus = (cmd_op_q == OP_SET) ? {NUM_FLAGS{1'b0}} : mask;
    end else begin
      s_bus = {NUM_FLAGS{1'b0}};
      r_bus = {NUM_FLAGS{1'b0}};
    end
  end

  assign req_a_ready  = grant_a;
  assign req_b_ready  = grant_b;
  assign busy         = !rst && (state_q == ST_APPLY);
  assign err_conflict = !rst && (state_q == ST_IDLE) && req_a_valid && req_b_valid
                        && (req_a_idx == req_b_idx) && (req_a_op != req_b_op);

  generate
    for (genvar g = 0; g < NUM_FLAGS; g++) begin : g_bank
      sr_flip_flop u_ff (
        .clk (clk),
        .S   (s_bus[g]),
        .R   (r_bus[g]),
        .Q   (flags[g]),
        .Qn  (flags_n[g])
      );
    end
  endgenerate

  sr_flag_controller_chk #(.NUM_FLAGS(NUM_FLAGS)) u_chk (
    .clk   (clk),
    .s_bus (s_bus),
    .r_bus (r_bus)
  );

endmodule

// File: tb/tb_sr_flag_controller.sv
// Bench for sr_flag_controller: a per-cycle vector table (inputs plus expected
// ready/busy/err) and a scoreboard of expected flag values that become due two
// cycles after each expected accept.
module tb_sr_flag_controller;

  logic       clk;
  logic       rst;
  logic       req_a_valid;
  logic [1:0] req_a_idx;
  logic       req_a_op;
  logic       req_a_ready;
  logic       req_b_valid;
  logic [1:0] req_b_idx;
  logic       req_b_op;
  logic       req_b_ready;
  logic       busy;
  logic       err_conflict;
  logic [3:0] flags;
  logic [3:0] flags_n;

  sr_flag_controller #(.NUM_FLAGS(4), .IDX_W(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_a_valid  (req_a_valid),
    .req_a_idx    (req_a_idx),
    .req_a_op     (req_a_op),
    .req_a_ready  (req_a_ready),
    .req_b_valid  (req_b_valid),
    .req_b_idx    (req_b_idx),
    .req_b_op     (req_b_op),
    .req_b_ready  (req_b_ready),
    .busy         (busy),
    .err_conflict (err_conflict),
    .flags        (flags),
    .flags_n      (flags_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       av;
    logic [1:0] aidx;
    logic       aop;
    logic       bv;
    logic [1:0] bidx;
    logic       bop;
    logic       ea;
    logic       eb;
    logic       ebusy;
    logic       eerr;
  } vec_t;

  typedef struct {
    int         due;
    logic [3:0] val;
  } sb_t;

  vec_t       vecs[$];
  sb_t        sbq[$];
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  logic [3:0] model_flags = 4'b0000;
  logic [3:0] cur_exp = 4'b0000;
  bit         flags_known = 1'b0;

  function automatic vec_t mk(input int r, input int av, input int ai, input int ao,
                              input int bv, input int bi, input int bo,
                              input int ea, input int eb, input int ebusy, input int eerr);
    vec_t v;
    v.rst = r[0];  v.av = av[0]; v.aidx = ai[1:0]; v.aop = ao[0];
    v.bv = bv[0];  v.bidx = bi[1:0]; v.bop = bo[0];
    v.ea = ea[0];  v.eb = eb[0]; v.ebusy = ebusy[0]; v.eerr = eerr[0];
    return v;
  endfunction

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%b expected=%b", name, cyc, act, exp);
    end
  endtask

  // Apply one row just after a negedge, compare mid-cycle, then cross the posedge.
  task automatic run_row(input vec_t v);
    logic [1:0] idx;
    logic       op;
    rst = v.rst;
    req_a_valid = v.av; req_a_idx = v.aidx; req_a_op = v.aop;
    req_b_valid = v.bv; req_b_idx = v.bidx; req_b_op = v.bop;
    #1;
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      cur_exp = sbq[0].val;
      void'(sbq.pop_front());
    end
    chk("a_ready", {3'b000, req_a_ready}, {3'b000, v.ea});
    chk("b_ready", {3'b000, req_b_ready}, {3'b000, v.eb});
    chk("busy", {3'b000, busy}, {3'b000, v.ebusy});
    chk("err_conflict", {3'b000, err_conflict}, {3'b000, v.eerr});
    if (flags_known) begin
      chk("flags", flags, cur_exp);
      chk("flags_n", flags_n, ~cur_exp);
    end
    if (v.ea || v.eb) begin
      idx = v.ea ? v.aidx : v.bidx;
      op  = v.ea ? v.aop : v.bop;
      model_flags[idx] = op;
      sbq.push_back('{cyc + 2, model_flags});
    end
    @(posedge clk);
    if (v.rst) begin
      sbq.delete();
      model_flags = 4'b0000;
      cur_exp     = 4'b0000;
      flags_known = 1'b1;
    end
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    rst = 1'b1;
    req_a_valid = 1'b0; req_a_idx = 2'd0; req_a_op = 1'b0;
    req_b_valid = 1'b0; req_b_idx = 2'd0; req_b_op = 1'b0;

    //                 r av ai ao bv bi bo  ea eb bsy err
    // reset, two cycles, then idle
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0));
    // single A set idx2
    vecs.push_back(mk(0, 1, 2, 1, 0, 0, 0,  1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0));
    // tie from reset: A set idx0 wins, B set idx1 follows
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 1, 1, 1,  1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 1,  0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 1,  0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0));
    // A clr idx0 so rr_last = A
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0));
    // conflict on idx3: B clr first, then A set; final flags[3]=1
    vecs.push_back(mk(0, 1, 3, 1, 1, 3, 0,  0, 1, 0, 1));
    vecs.push_back(mk(0, 1, 3, 1, 0, 3, 0,  0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 3, 1, 0, 0, 0,  1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0));
    // back-to-back A with valid held
    vecs.push_back(mk(0, 1, 1, 1, 0, 0, 0,  1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 1, 0, 0, 0,  0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 3, 0, 0, 0, 0,  1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 3, 0, 0, 0, 0,  0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 1, 0, 0, 0,  1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0));
    // redundant B set idx1
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 1,  0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0));
    // reset lands in APPLY of A set idx2: pulse dropped, flags clear
    vecs.push_back(mk(0, 1, 2, 1, 0, 0, 0,  1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0));

    @(negedge clk);
    foreach (vecs[k]) run_row(vecs[k]);

    // Hand sequence: A holds valid for 8 cycles setting idx 0..3 in turn;
    // ready must pulse on every other cycle and busy fill the gaps.
    for (int i = 0; i < 8; i++) begin
      run_row(mk(0, 1, (i / 2) % 4, 1, 0, 0, 0, (i % 2 == 0) ? 1 : 0, 0, (i % 2 == 1) ? 1 : 0, 0));
    end
    run_row(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    run_row(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    chk("final_flags", flags, 4'b1111);
    chk("sb_drained", sbq.size() == 0 ? 4'd0 : 4'd1, 4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
